// File: rtl/controle_jogada_pkg.sv
// Shared definitions for the tic-tac-toe move controller: state encoding,
// board geometry, player ids and the cell mask helper.
package controle_jogada_pkg;

  localparam int NUM_CASAS = 9;
  localparam int POS_MAX   = 8;

  localparam logic JOGADOR_X = 1'b0;
  localparam logic JOGADOR_O = 1'b1;

  typedef enum logic [1:0] {
    PARADO,
    ESPERA,
    VERIFICA,
    REGISTRA
  } estado_t;

  // One-hot mask of a keypad cell; positions beyond the board give an empty mask.
  function automatic logic [NUM_CASAS-1:0] mascara_casa(input logic [3:0] pos);
    if (pos > 4'(POS_MAX))
      mascara_casa = '0;
    else
      mascara_casa = NUM_CASAS'(1) << pos;
  endfunction

endpackage

// File: rtl/controle_jogada_if.sv
// Signal bundle between the move controller, the player inputs and the two
// board registers.
interface controle_jogada_if;
  import controle_jogada_pkg::*;

  logic                 iniciar;
  logic                 fim;
  logic                 jogar;
  logic [3:0]           posicao;
  logic [NUM_CASAS-1:0] board_x;
  logic [NUM_CASAS-1:0] board_o;
  logic [NUM_CASAS-1:0] D;
  logic                 en_x;
  logic                 en_o;
  logic                 vez;
  logic                 jogada_invalida;
  logic                 timeout;
  logic                 aguardando;

  modport master (
    output iniciar, fim, jogar, posicao, board_x, board_o,
    input  D, en_x, en_o, vez, jogada_invalida, timeout, aguardando
  );

  modport slave (
    input  iniciar, fim, jogar, posicao, board_x, board_o,
    output D, en_x, en_o, vez, jogada_invalida, timeout, aguardando
  );

endinterface

// File: rtl/controle_jogada_detector_borda.sv
// Rising-edge detector: the previous input level is registered and the pulse
// is high for the one cycle in which the input is high after being low.
module detector_borda (
  input  logic clock,
  input  logic clear,
  input  logic sinal,
  output logic pulso
);

  logic sinal_d;

  always_ff @(posedge clock or posedge clear) begin
    if (clear)
      sinal_d <= 1'b0;
    else
      sinal_d <= sinal;
  end

  assign pulso = sinal & ~sinal_d;

endmodule

// File: rtl/controle_jogada.sv
// Move controller: validates a keypad press against both boards and issues a
// single-cycle write of the updated board to the current player's register.
module controle_jogada
  import controle_jogada_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input logic              clock,
  input logic              clear,
  controle_jogada_if.slave bus
);

  localparam int             TW        = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);

  estado_t              estado, estado_n;
  logic                 vez_r, vez_n;
  logic [TW-1:0]        timer, timer_n, timer_inc;
  logic [3:0]           pos_r, pos_n;
  logic [NUM_CASAS-1:0] d_r, d_n;
  logic                 inval_r, inval_n;
  logic                 tout_r, tout_n;
  logic                 borda;
  logic [NUM_CASAS-1:0] mascara;
  logic                 jogada_legal;

  detector_borda u_borda (
    .clock (clock),
    .clear (clear),
    .sinal (bus.jogar),
    .pulso (borda)
  );

  // The timer saturates so a press on the expiry cycle cannot wrap it to zero.
  assign timer_inc    = (timer == TIMER_MAX) ? timer : timer + TW'(1);
  assign mascara      = mascara_casa(pos_r);
  assign jogada_legal = (mascara != '0) && (((bus.board_x | bus.board_o) & mascara) == '0);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      estado  <= PARADO;
      vez_r   <= JOGADOR_X;
      timer   <= '0;
      pos_r   <= '0;
      d_r     <= '0;
      inval_r <= 1'b0;
      tout_r  <= 1'b0;
    end else begin
      estado  <= estado_n;
      vez_r   <= vez_n;
      timer   <= timer_n;
      pos_r   <= pos_n;
      d_r     <= d_n;
      inval_r <= inval_n;
      tout_r  <= tout_n;
    end
  end

  // iniciar overrides everything; fim aborts a move unless the write is already under way.
  always_comb begin
    estado_n = estado;
    vez_n    = vez_r;
    timer_n  = timer;
    pos_n    = pos_r;
    d_n      = d_r;
    inval_n  = 1'b0;
    tout_n   = 1'b0;

    if (bus.iniciar) begin
      estado_n = ESPERA;
      vez_n    = JOGADOR_X;
      timer_n  = '0;
    end else begin
      case (estado)
        PARADO: begin
          estado_n = PARADO;
        end
        ESPERA: begin
          if (bus.fim) begin
            estado_n = PARADO;
          end else if (borda) begin
            pos_n    = bus.posicao;
            timer_n  = timer_inc;
            estado_n = VERIFICA;
          end else if (timer == TIMER_MAX) begin
            tout_n  = 1'b1;
            vez_n   = ~vez_r;
            timer_n = '0;
          end else begin
            timer_n = timer_inc;
          end
        end
        VERIFICA: begin
          timer_n = timer_inc;
          if (bus.fim) begin
            estado_n = PARADO;
          end else if (jogada_legal) begin
            d_n      = ((vez_r == JOGADOR_O) ? bus.board_o : bus.board_x) | mascara;
            estado_n = REGISTRA;
          end else begin
            inval_n  = 1'b1;
            estado_n = ESPERA;
          end
        end
        REGISTRA: begin
          vez_n    = ~vez_r;
          timer_n  = '0;
          estado_n = bus.fim ? PARADO : ESPERA;
        end
        default: begin
          estado_n = PARADO;
        end
      endcase
    end
  end

  assign bus.D               = d_r;
  assign bus.en_x            = (estado == REGISTRA) && (vez_r == JOGADOR_X);
  assign bus.en_o            = (estado == REGISTRA) && (vez_r == JOGADOR_O);
  assign bus.vez             = vez_r;
  assign bus.jogada_invalida = inval_r;
  assign bus.timeout         = tout_r;
  assign bus.aguardando      = (estado == ESPERA);

endmodule

// File: tb/tb_controle_jogada.sv
// Self-checking bench for controle_jogada: directed scenarios plus a random
// game checked against a board-level model of the move rules.
module tb_controle_jogada;

  localparam int TIMEOUT = 8;

  logic       clock = 1'b0;
  logic       clear;
  logic [8:0] boardX, boardO;
  logic       vezModel;
  int         errors = 0;
  int         checks = 0;

  controle_jogada_if bus ();

  controle_jogada #(.TIMEOUT_CICLOS(TIMEOUT)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  assign bus.board_x = boardX;
  assign bus.board_o = boardO;

  always #5 clock = ~clock;

  // A move is legal when the cell exists and neither player holds it.
  function automatic bit legalModel(input int pos, input logic [8:0] bx, input logic [8:0] bo);
    if (pos > 8) return 1'b0;
    return (((int'(bx) | int'(bo)) >> pos) & 1) == 0;
  endfunction

  function automatic logic [8:0] boardAfter(input int pos, input logic [8:0] own);
    return 9'(int'(own) | (1 << pos));
  endfunction

  task automatic applyIniciar();
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    vezModel = 1'b0;
  endtask

  // Presses a key and records what the controller does over ncyc cycles.
  task automatic applyStimulus(input int pos, input int hold, input int ncyc,
                               output int nx, output int no, output int ninv,
                               output int ntout, output int firstEn,
                               output logic [8:0] dAt);
    nx = 0; no = 0; ninv = 0; ntout = 0; firstEn = -1; dAt = '0;
    bus.posicao = 4'(pos);
    bus.jogar = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clock);
      if (bus.en_x) begin nx++; if (firstEn < 0) firstEn = c; dAt = bus.D; end
      if (bus.en_o) begin no++; if (firstEn < 0) firstEn = c; dAt = bus.D; end
      if (bus.jogada_invalida) ninv++;
      if (bus.timeout) ntout++;
      if (c == hold) bus.jogar = 1'b0;
    end
    bus.jogar = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    bus.iniciar = 0; bus.fim = 0; bus.jogar = 0; bus.posicao = 0;
    boardX = '0; boardO = '0; vezModel = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if ({bus.en_x, bus.en_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_en: got %b expected 00", {bus.en_x, bus.en_o}); end
    checks++; if (bus.D !== 9'h000) begin errors++; $display("[TB] FAIL reset_D: got %h expected 000", bus.D); end
    checks++; if ({bus.vez, bus.aguardando, bus.jogada_invalida, bus.timeout} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {bus.vez, bus.aguardando, bus.jogada_invalida, bus.timeout}); end
    clear = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (bus.aguardando !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: aguardando got %b expected 0", bus.aguardando); end
  endtask

  task automatic test_start_legal();
    int nx, no, ninv, ntout, firstEn;
    logic [8:0] dAt;
    applyIniciar();
    applyStimulus(4, 5, 6, nx, no, ninv, ntout, firstEn, dAt);
    checks++; if (nx !== 1 || no !== 0) begin errors++; $display("[TB] FAIL start_en_count: got x=%0d o=%0d expected x=1 o=0", nx, no); end
    checks++; if (firstEn !== 2) begin errors++; $display("[TB] FAIL start_latency: got %0d expected 2", firstEn); end
    checks++; if (dAt !== 9'b000010000) begin errors++; $display("[TB] FAIL start_D: got %b expected 000010000", dAt); end
    checks++; if (bus.vez !== 1'b1 || bus.aguardando !== 1'b1) begin errors++; $display("[TB] FAIL start_turn: got vez=%b aguardando=%b expected 1 1", bus.vez, bus.aguardando); end
    boardX = 9'h010;
    vezModel = 1'b1;
  endtask

  task automatic test_occupied();
    int nx, no, ninv, ntout, firstEn;
    logic [8:0] dAt;
    applyStimulus(4, 1, 4, nx, no, ninv, ntout, firstEn, dAt);
    checks++; if (ninv !== 1) begin errors++; $display("[TB] FAIL occupied_invalid: got %0d pulses expected 1", ninv); end
    checks++; if (no !== 0 || nx !== 0) begin errors++; $display("[TB] FAIL occupied_no_write: got x=%0d o=%0d expected 0 0", nx, no); end
    checks++; if (bus.vez !== 1'b1 || ntout !== 0) begin errors++; $display("[TB] FAIL occupied_vez: got vez=%b timeouts=%0d expected 1 0", bus.vez, ntout); end
  endtask

  task automatic test_out_of_range();
    int invAt = -1, toutAt = -1, ninv = 0, ntout = 0, nen = 0;
    applyIniciar();
    checks++; if (bus.timeout !== 1'b0 || bus.vez !== 1'b0) begin errors++; $display("[TB] FAIL iniciar_priority: got timeout=%b vez=%b expected 0 0", bus.timeout, bus.vez); end
    bus.posicao = 4'd12;
    bus.jogar = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (bus.jogada_invalida) begin ninv++; invAt = k; end
      if (bus.timeout) begin ntout++; toutAt = k; end
      if (bus.en_x || bus.en_o) nen++;
      if (k == 1) bus.jogar = 1'b0;
    end
    checks++; if (ninv !== 1 || invAt !== 2) begin errors++; $display("[TB] FAIL range_invalid: got %0d pulses at %0d expected 1 at 2", ninv, invAt); end
    checks++; if (nen !== 0) begin errors++; $display("[TB] FAIL range_no_write: got %0d expected 0", nen); end
    checks++; if (ntout !== 1 || toutAt !== TIMEOUT) begin errors++; $display("[TB] FAIL range_timer_kept: got %0d timeouts at %0d expected 1 at %0d", ntout, toutAt, TIMEOUT); end
    checks++; if (bus.vez !== 1'b1) begin errors++; $display("[TB] FAIL range_vez: got %b expected 1", bus.vez); end
  endtask

  task automatic test_timeout();
    int ntout = 0, firstAt = -1, lastAt = -1, other = 0;
    applyIniciar();
    for (int k = 1; k <= 2 * TIMEOUT + 1; k++) begin
      @(negedge clock);
      if (bus.timeout) begin ntout++; if (firstAt < 0) firstAt = k; lastAt = k; end
      if (bus.en_x || bus.en_o || bus.jogada_invalida) other++;
      if (k == TIMEOUT) begin
        checks++; if (bus.vez !== 1'b1) begin errors++; $display("[TB] FAIL timeout_vez_toggle: got %b expected 1", bus.vez); end
      end
    end
    checks++; if (ntout !== 2 || firstAt !== TIMEOUT || lastAt !== 2 * TIMEOUT) begin errors++; $display("[TB] FAIL timeout_pulses: got %0d at %0d/%0d expected 2 at %0d/%0d", ntout, firstAt, lastAt, TIMEOUT, 2 * TIMEOUT); end
    checks++; if (bus.vez !== 1'b0 || other !== 0) begin errors++; $display("[TB] FAIL timeout_restart: got vez=%b other=%0d expected 0 0", bus.vez, other); end
  endtask

  task automatic test_press_on_expiry();
    int ntout = 0, nx = 0, enAt = -1;
    logic [8:0] dAt = '0;
    logic [8:0] expD;
    applyIniciar();
    expD = boardAfter(0, boardX);
    for (int k = 1; k <= TIMEOUT + 3; k++) begin
      @(negedge clock);
      if (bus.timeout) ntout++;
      if (bus.en_x) begin nx++; enAt = k; dAt = bus.D; end
      if (k == TIMEOUT - 1) begin bus.posicao = 4'd0; bus.jogar = 1'b1; end
      if (k == TIMEOUT) bus.jogar = 1'b0;
    end
    checks++; if (ntout !== 0) begin errors++; $display("[TB] FAIL expiry_press_timeout: got %0d expected 0", ntout); end
    checks++; if (nx !== 1 || enAt !== TIMEOUT + 1 || dAt !== expD) begin errors++; $display("[TB] FAIL expiry_press_write: got %0d at %0d D=%h expected 1 at %0d D=%h", nx, enAt, dAt, TIMEOUT + 1, expD); end
    checks++; if (bus.vez !== 1'b1) begin errors++; $display("[TB] FAIL expiry_press_vez: got %b expected 1", bus.vez); end
    boardX = expD;
  endtask

  task automatic test_game_end();
    int nx = 0, no, ninv, ntout, firstEn;
    logic [8:0] dAt = '0;
    logic [8:0] expD;
    applyIniciar();
    expD = boardAfter(8, boardX);
    bus.posicao = 4'd8;
    bus.jogar = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (bus.en_x) begin nx++; dAt = bus.D; end
      if (k == 1) bus.jogar = 1'b0;
      if (k == 2) bus.fim = 1'b1;
    end
    checks++; if (nx !== 1 || dAt !== expD) begin errors++; $display("[TB] FAIL fim_write_completes: got %0d D=%h expected 1 D=%h", nx, dAt, expD); end
    checks++; if (bus.aguardando !== 1'b0) begin errors++; $display("[TB] FAIL fim_parado: aguardando got %b expected 0", bus.aguardando); end
    boardX = expD;
    applyStimulus(5, 1, 4, nx, no, ninv, ntout, firstEn, dAt);
    checks++; if (nx + no + ninv + ntout !== 0 || bus.aguardando !== 1'b0) begin errors++; $display("[TB] FAIL fim_ignores_press: got events=%0d aguardando=%b expected 0 0", nx + no + ninv + ntout, bus.aguardando); end
    bus.fim = 1'b0;
  endtask

  task automatic test_iniciar_in_verifica();
    int nen = 0;
    applyIniciar();
    bus.posicao = 4'd2;
    bus.jogar = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (bus.en_x || bus.en_o) nen++;
      if (k == 1) bus.iniciar = 1'b1;
      if (k == 2) bus.iniciar = 1'b0;
      if (k == 4) bus.jogar = 1'b0;
    end
    checks++; if (nen !== 0) begin errors++; $display("[TB] FAIL iniciar_suppresses_write: got %0d enables expected 0", nen); end
    checks++; if (bus.vez !== 1'b0 || bus.aguardando !== 1'b1) begin errors++; $display("[TB] FAIL iniciar_restart: got vez=%b aguardando=%b expected 0 1", bus.vez, bus.aguardando); end
  endtask

  task automatic test_async_reset();
    int nx, no, ninv, ntout, firstEn;
    logic [8:0] dAt;
    bus.posicao = 4'd3;
    bus.jogar = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (bus.en_x !== 1'b1) begin errors++; $display("[TB] FAIL async_pre_write: en_x got %b expected 1", bus.en_x); end
    #2 clear = 1'b1;
    #1;
    checks++; if ({bus.en_x, bus.en_o} !== 2'b00) begin errors++; $display("[TB] FAIL async_en_drop: got %b expected 00", {bus.en_x, bus.en_o}); end
    @(negedge clock);
    clear = 1'b0;
    bus.jogar = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (bus.aguardando !== 1'b0 || bus.vez !== 1'b0) begin errors++; $display("[TB] FAIL async_parado: got aguardando=%b vez=%b expected 0 0", bus.aguardando, bus.vez); end
    applyStimulus(3, 1, 4, nx, no, ninv, ntout, firstEn, dAt);
    checks++; if (nx + no + ninv !== 0) begin errors++; $display("[TB] FAIL async_idle_press: got %0d events expected 0", nx + no + ninv); end
  endtask

  task automatic test_random_game();
    int nx, no, ninv, ntout, firstEn, pos, hold;
    logic [8:0] dAt, expD;
    bit legal;
    applyIniciar();
    boardX = 9'($urandom) & 9'($urandom);
    boardO = 9'($urandom) & ~boardX & 9'($urandom);
    for (int t = 0; t < 40; t++) begin
      pos  = int'($urandom_range(0, 11));
      hold = int'($urandom_range(1, 3));
      legal = legalModel(pos, boardX, boardO);
      expD = boardAfter(pos, vezModel ? boardO : boardX);
      applyStimulus(pos, hold, 4, nx, no, ninv, ntout, firstEn, dAt);
      if (legal) begin
        checks++; if (nx !== (vezModel ? 0 : 1) || no !== (vezModel ? 1 : 0) || firstEn !== 2) begin errors++; $display("[TB] FAIL rand_write t=%0d: got x=%0d o=%0d at %0d expected vez=%b at 2", t, nx, no, firstEn, vezModel); end
        checks++; if (dAt !== expD || ninv !== 0) begin errors++; $display("[TB] FAIL rand_D t=%0d: got %h inv=%0d expected %h inv=0", t, dAt, ninv, expD); end
        if (vezModel) boardO = expD; else boardX = expD;
        vezModel = ~vezModel;
      end else begin
        checks++; if (ninv !== 1 || nx + no !== 0) begin errors++; $display("[TB] FAIL rand_illegal t=%0d pos=%0d: got inv=%0d writes=%0d expected 1 0", t, pos, ninv, nx + no); end
      end
      checks++; if (bus.vez !== vezModel || ntout !== 0) begin errors++; $display("[TB] FAIL rand_vez t=%0d: got vez=%b timeouts=%0d expected %b 0", t, bus.vez, ntout, vezModel); end
      if (!legal || (boardX | boardO) == 9'h1ff) begin
        applyIniciar();
        boardX = 9'($urandom) & 9'($urandom);
        boardO = 9'($urandom) & ~boardX & 9'($urandom);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_legal();
    test_occupied();
    test_out_of_range();
    test_timeout();
    test_press_on_expiry();
    test_game_end();
    test_iniciar_in_verifica();
    test_async_reset();
    test_random_game();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
